i2s_master_rx: RTL

I2S master receiver for the microphone front end. It generates BCLK and WS from the system clock and shifts in the serial data line. It assembles the left-channel word, formats it, and emits a 32-bit sample with a 1-cycle sample_valid pulse. The outputs drive sample_in/sample_valid of the FFT input buffer directly; there is no backpressure.

---
 rtl/i2s_master_rx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/i2s_master_rx.sv
// I2S master receiver: divides clk down to BCLK/WS, shifts in the left-channel
// word from the mic and emits it as a sign-extended 32-bit sample with a
// one-cycle valid pulse. The right channel is ignored.
module i2s_master_rx #(
  parameter int CLK_DIV   = 12,  // clk cycles per BCLK half-period (>= 2)
  parameter int DATA_BITS = 24   // significant MSB-aligned bits per slot (1..32)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        i2s_sd,
  output logic        i2s_bclk,
  output logic        i2s_ws,
  output logic [31:0] sample_out,
  output logic        sample_valid,
  output logic [15:0] sample_count
);

  localparam int              DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int              EXT_SHIFT = 32 - DATA_BITS;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             bclk_reg;
  logic             ws_reg;
  logic [5:0]       slot_cnt_reg;
  logic [31:0]      shift_reg;
  logic             word_done_reg;
  logic [31:0]      sample_reg;
  logic             valid_reg;
  logic [15:0]      count_reg;

  logic        div_term;
  logic        rise_evt;
  logic        fall_evt;
  logic        left_slot;
  logic [5:0]  slot_next;
  logic [31:0] sample_next;

  // Event decode: the divider terminal count is where BCLK toggles; the
  // current BCLK level tells whether that toggle is a rising or falling edge.
  always_comb begin
    div_term    = (div_cnt_reg == DIV_LAST);
    rise_evt    = enable && div_term && !bclk_reg;
    fall_evt    = enable && div_term && bclk_reg;
    left_slot   = (slot_cnt_reg >= 6'd1) && (slot_cnt_reg <= 6'd32);
    slot_next   = slot_cnt_reg + 6'd1;
    // Arithmetic shift keeps the top DATA_BITS and sign-extends them.
    sample_next = 32'($signed(shift_reg) >>> EXT_SHIFT);
  end

  // Clock divider, BCLK generation and slot/word-select tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_reg  <= '0;
      bclk_reg     <= 1'b0;
      slot_cnt_reg <= 6'd0;
      ws_reg       <= 1'b0;
    end else if (!enable) begin
      div_cnt_reg  <= '0;
      bclk_reg     <= 1'b0;
      slot_cnt_reg <= 6'd0;
      ws_reg       <= 1'b0;
    end else begin
      if (div_term) begin
        div_cnt_reg <= '0;
        bclk_reg    <= ~bclk_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
      if (fall_evt) begin
        slot_cnt_reg <= slot_next;
        ws_reg       <= slot_next[5];
      end
    end
  end

  // Serial capture of left-word bits on BCLK rise; flag completion at slot 32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg     <= '0;
      word_done_reg <= 1'b0;
    end else begin
      // The completion flag is not gated by enable here: once the last bit
      // is in, the word is delivered even if enable drops on the next edge.
      word_done_reg <= rise_evt && (slot_cnt_reg == 6'd32);
      if (!enable) begin
        shift_reg <= '0;
      end else if (rise_evt && left_slot) begin
        shift_reg <= {shift_reg[30:0], i2s_sd};
      end
    end
  end

  // Output stage: publish the formatted word, pulse valid, bump the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_reg <= '0;
      valid_reg  <= 1'b0;
      count_reg  <= '0;
    end else begin
      valid_reg <= word_done_reg;
      if (word_done_reg) begin
        sample_reg <= sample_next;
        count_reg  <= count_reg + 16'd1;
      end
    end
  end

  assign i2s_bclk     = bclk_reg;
  assign i2s_ws       = ws_reg;
  assign sample_out   = sample_reg;
  assign sample_valid = valid_reg;
  assign sample_count = count_reg;

  // Expose the count register under a stable name for preloading in test.
  logic [15:0] sample_count_reg;
  assign sample_count_reg = count_reg;

endmodule
